// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: register index type and pipeline controller state.
`default_nettype none

package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/hazard_detect.sv
// Load-use hazard detection: a load in EX writes a register that the ID-stage instruction reads.
`default_nettype none

module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     i_ex_dREN,
  input  regbits_t i_ex_rd,
  input  regbits_t i_id_rs1,
  input  regbits_t i_id_rs2,
  output logic     o_lu
);

  logic w_rd_nonzero;
  logic w_src_match;

  // Register 0 is hardwired to zero, so a load into it never creates a dependency.
  assign w_rd_nonzero = (i_ex_rd != '0);
  assign w_src_match  = (i_ex_rd == i_id_rs1) | (i_ex_rd == i_id_rs2);
  assign o_lu         = i_ex_dREN & w_rd_nonzero & w_src_match;

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller for a 5-stage pipeline: latch enables, flushes, freeze, halt and stall counter.
`default_nettype none

module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             mem_halt,
  input  logic             ex_dREN,
  input  regbits_t         ex_rd,
  input  regbits_t         id_rs1,
  input  regbits_t         id_rs2,
  input  logic             ex_redirect,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             idex_freeze,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  state_t           r_state;
  logic             r_flush_pend;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_mem_busy;
  logic w_gen;
  logic w_lu;
  logic w_redir;
  logic w_hold;

  hazard_detect u_hazard_detect (
    .i_ex_dREN (ex_dREN),
    .i_ex_rd   (ex_rd),
    .i_id_rs1  (id_rs1),
    .i_id_rs2  (id_rs2),
    .o_lu      (w_lu)
  );

  assign w_mem_busy = (mem_dREN | mem_dWEN) & ~dhit;
  assign w_gen      = ihit & ~w_mem_busy;
  assign w_redir    = ex_redirect | r_flush_pend;
  // A pending redirect squashes the dependent instruction, so the load-use hold is moot.
  assign w_hold     = w_lu & ~w_redir;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= RUN;
      r_flush_pend <= 1'b0;
      r_stall_cnt  <= '0;
    end else if (r_state == RUN) begin
      if (mem_halt && w_gen) begin
        r_state <= HALTED;
      end
      // A redirect seen during a stall must survive until the latches actually advance.
      if (w_gen) begin
        r_flush_pend <= 1'b0;
      end else if (ex_redirect) begin
        r_flush_pend <= 1'b1;
      end
      if (!w_gen && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    idex_freeze = 1'b0;
    exmem_en    = 1'b0;
    exmem_flush = 1'b0;
    memwb_en    = 1'b0;
    halted      = 1'b1;
    if (r_state == RUN) begin
      halted      = 1'b0;
      pc_en       = w_gen & ~w_hold;
      ifid_en     = w_gen & ~w_hold;
      ifid_flush  = w_redir;
      idex_en     = w_gen;
      idex_flush  = w_redir;
      idex_freeze = w_hold;
      exmem_en    = w_gen;
      exmem_flush = mem_halt & w_gen;
      memwb_en    = w_gen;
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: rule-level model compared every cycle plus directed literal checks.
`default_nettype none

module tb_pipeline_ctrl;

  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             CLK;
  logic             nRST;
  logic             ihit, dhit, mem_dREN, mem_dWEN, mem_halt, ex_dREN, ex_redirect;
  logic [4:0]       ex_rd, id_rs1, id_rs2;
  logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush, idex_freeze;
  logic             exmem_en, exmem_flush, memwb_en, halted;
  logic [CNT_W-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  pipeline_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dREN),
    .mem_dWEN(mem_dWEN), .mem_halt(mem_halt), .ex_dREN(ex_dREN), .ex_rd(ex_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_redirect(ex_redirect), .pc_en(pc_en),
    .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_flush(idex_flush), .idex_freeze(idex_freeze), .exmem_en(exmem_en),
    .exmem_flush(exmem_flush), .memwb_en(memwb_en), .halted(halted),
    .stall_cnt(stall_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model state, expressed as the facts the pipeline must remember.
  bit m_halted = 0;
  bit m_owe_flush = 0;
  int m_stalls = 0;

  // Expected output vector {pc,ifid_en,ifid_fl,idex_en,idex_fl,idex_frz,exmem_en,exmem_fl,memwb_en,halted}
  function automatic logic [9:0] expect_outs();
    bit advancing, dependent, squash, bubble_hold;
    logic [9:0] v;
    if (m_halted) return 10'b0000000001;
    advancing   = ihit && !((mem_dREN || mem_dWEN) && !dhit);
    dependent   = ex_dREN && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
    squash      = ex_redirect || m_owe_flush;
    bubble_hold = dependent && !squash;
    v[9] = advancing && !bubble_hold;
    v[8] = advancing && !bubble_hold;
    v[7] = squash;
    v[6] = advancing;
    v[5] = squash;
    v[4] = bubble_hold;
    v[3] = advancing;
    v[2] = advancing && mem_halt;
    v[1] = advancing;
    v[0] = 1'b0;
    return v;
  endfunction

  always @(posedge CLK or negedge nRST) begin
    bit advancing;
    if (!nRST) begin
      m_halted    = 0;
      m_owe_flush = 0;
      m_stalls    = 0;
    end else if (!m_halted) begin
      advancing = ihit && !((mem_dREN || mem_dWEN) && !dhit);
      if (advancing && mem_halt) m_halted = 1;
      if (advancing) m_owe_flush = 0;
      else if (ex_redirect) m_owe_flush = 1;
      if (!advancing && m_stalls < SAT) m_stalls = m_stalls + 1;
    end
  end

  always @(negedge CLK) begin
    logic [9:0] got, want;
    got  = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, idex_freeze,
            exmem_en, exmem_flush, memwb_en, halted};
    want = expect_outs();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL model_ctrl t=%0t: got %b want %b", $time, got, want);
    end
    total++;
    if (int'(stall_cnt) != m_stalls) begin
      bad++;
      $display("FAIL model_cnt t=%0t: got %0d want %0d", $time, stall_cnt, m_stalls);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic idle();
    ihit = 1; dhit = 0; mem_dREN = 0; mem_dWEN = 0; mem_halt = 0;
    ex_dREN = 0; ex_redirect = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
  endtask

  task automatic next_drive();
    @(posedge CLK); #1;
  endtask

  task automatic settle();
    @(negedge CLK); #1;
  endtask

  initial begin
    idle();
    ihit = 0;
    nRST = 0;
    repeat (2) @(posedge CLK);
    settle();
    chk("reset_en", {31'b0, ifid_en | idex_en | exmem_en | memwb_en | pc_en}, 0);
    chk("reset_halted", halted, 0);
    chk("reset_cnt", stall_cnt, 0);

    next_drive(); nRST = 1; ihit = 1;
    settle();
    chk("run_en", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'b11111);
    chk("run_flush", {ifid_flush, idex_flush, idex_freeze, exmem_flush}, 0);
    chk("run_cnt", stall_cnt, 0);

    next_drive(); ex_dREN = 1; ex_rd = 5; id_rs2 = 5;
    settle();
    chk("lu_ctrl", {pc_en, ifid_en, idex_en, idex_freeze}, 4'b0011);

    next_drive(); ex_rd = 0; id_rs2 = 0;
    settle();
    chk("lu_r0", {pc_en, ifid_en, idex_en, idex_freeze}, 4'b1110);

    next_drive(); idle(); mem_dREN = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("dwait_en", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 0);
      next_drive();
    end
    dhit = 1;
    settle();
    chk("dwait_cnt", stall_cnt, 3);
    chk("dwait_done", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'b11111);

    next_drive(); idle(); mem_dREN = 1; ex_redirect = 1; ex_dREN = 1; ex_rd = 7; id_rs1 = 7;
    settle();
    chk("redir_busy", {ifid_flush, idex_flush, idex_freeze, pc_en}, 4'b1100);
    next_drive(); ex_redirect = 0;
    settle();
    chk("redir_pend", {ifid_flush, idex_flush}, 2'b11);
    chk("redir_cnt", stall_cnt, 4);
    next_drive(); dhit = 1;
    settle();
    chk("redir_gen", {ifid_flush, idex_flush, idex_freeze, pc_en, ifid_en}, 5'b11011);
    next_drive(); mem_dREN = 0; dhit = 0;
    settle();
    chk("redir_clear", {ifid_flush, idex_flush, idex_freeze, pc_en}, 4'b0010);
    chk("redir_cnt2", stall_cnt, 5);
    next_drive(); ex_redirect = 1;
    settle();
    chk("redir_lu", {ifid_flush, idex_freeze, pc_en}, 3'b101);
    next_drive(); idle();
    settle();
    chk("redir_nopend", {ifid_flush, idex_flush}, 0);

    next_drive(); mem_halt = 1;
    settle();
    chk("halt_flush", {exmem_flush, exmem_en, halted}, 3'b110);
    next_drive(); mem_halt = 0; ex_redirect = 1;
    settle();
    chk("halted", halted, 1);
    chk("halted_ctrl", {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, idex_freeze,
                        exmem_en, exmem_flush, memwb_en}, 0);
    next_drive(); ex_redirect = 0; ihit = 0;
    next_drive();
    settle();
    chk("halted_cnt", stall_cnt, 5);
    chk("halted_sticky", halted, 1);
    next_drive(); nRST = 0;
    settle();
    chk("rst_async_halted", halted, 0);
    chk("rst_async_cnt", stall_cnt, 0);

    next_drive(); nRST = 1; idle(); ihit = 0;
    repeat (20) next_drive();
    settle();
    chk("sat_cnt", stall_cnt, SAT);
    next_drive(); ihit = 1;
    settle();
    chk("sat_hold", stall_cnt, 15);
    chk("sat_run", {pc_en, idex_en}, 2'b11);

    next_drive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
